// File: rtl/echo_capture.sv
// Receive-side A-scan capture: after a trigger edge and a programmable delay, it stores a gated sample window and tracks peak, peak position and flaw.
// Define ECHO_RECTIFY_EN to full-wave rectify samples about midscale before storage; this adds one cycle of latency.
module echo_capture #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          trig_i,
    input  logic [DW-1:0] adc_data_i,
    input  logic [15:0]   delay_i,
    input  logic [AW:0]   length_i,
    input  logic [DW-1:0] threshold_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] peak_o,
    output logic [AW-1:0] peak_idx_o,
    output logic          flaw_o,
    output logic [7:0]    overrun_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [16:0]   CNT_ONE = 17'd1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DW-1:0] sample;
    logic [16:0]   lat_adj;

`ifdef ECHO_RECTIFY_EN
    function automatic logic [DW-1:0] rectify(input logic [DW-1:0] a);
        logic [DW-2:0] r;
        r = a[DW-1] ? a[DW-2:0] : ~a[DW-2:0];
        return {r, 1'b0};
    endfunction

    logic [DW-1:0] rect_q;

    // Rectifier stage: the extra cycle is absorbed by one additional delay count.
    always_ff @(posedge clk_i) begin
        rect_q <= rectify(adc_data_i);
    end

    assign sample  = rect_q;
    assign lat_adj = CNT_ONE;
`else
    assign sample  = adc_data_i;
    assign lat_adj = '0;
`endif

    state_t        state_q, state_d;
    logic          trig_q;
    logic [16:0]   cnt_q, cnt_d;
    logic [AW:0]   rem_q, rem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] thr_q, thr_d;
    logic [DW-1:0] peak_q, peak_d;
    logic [AW-1:0] pidx_q, pidx_d;
    logic          flaw_q, flaw_d;
    logic          done_q, done_d;
    logic [7:0]    ovr_q, ovr_d;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] mem_q [2**AW];

    logic          trig_edge;
    logic          busy;
    logic          wr_en;
    logic [16:0]   eff_delay;
    logic [AW:0]   len_clamp;

    assign trig_edge = trig_i & ~trig_q;
    assign busy      = (state_q == DELAY) || (state_q == CAPTURE);
    assign eff_delay = {1'b0, delay_i} + lat_adj;
    assign len_clamp = (length_i > DEPTH) ? DEPTH : length_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        wr_ptr_d = wr_ptr_q;
        thr_d    = thr_q;
        peak_d   = peak_q;
        pidx_d   = pidx_q;
        flaw_d   = flaw_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        wr_en    = 1'b0;

        if (trig_edge && busy) begin
            ovr_d = sat_inc(ovr_q);
        end

        if (!en_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // First DONE cycle: peak has settled, so publish done and flaw now.
                    if (state_q == DONE && !done_q) begin
                        done_d = 1'b1;
                        flaw_d = (peak_q >= thr_q);
                    end
                    if (trig_edge) begin
                        cnt_d    = eff_delay;
                        rem_d    = len_clamp;
                        wr_ptr_d = '0;
                        thr_d    = threshold_i;
                        peak_d   = '0;
                        pidx_d   = '0;
                        flaw_d   = 1'b0;
                        done_d   = 1'b0;
                        if (eff_delay != '0) begin
                            state_d = DELAY;
                        end else if (len_clamp == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = (rem_q == '0) ? DONE : CAPTURE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                CAPTURE: begin
                    wr_en = 1'b1;
                    if (sample > peak_q) begin
                        peak_d = sample;
                        pidx_d = wr_ptr_q;
                    end
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rem_d    = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            wr_ptr_q  <= '0;
            thr_q     <= '0;
            peak_q    <= '0;
            pidx_q    <= '0;
            flaw_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig_i;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            thr_q    <= thr_d;
            peak_q   <= peak_d;
            pidx_q   <= pidx_d;
            flaw_q   <= flaw_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
    end

    // Sample buffer: not reset; a simultaneous read returns the pre-write word.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign busy_o     = busy;
    assign done_o     = done_q;
    assign peak_o     = peak_q;
    assign peak_idx_o = pidx_q;
    assign flaw_o     = flaw_q;
    assign overrun_o  = ovr_q;

endmodule

// File: doc/echo_capture.md
# echo_capture

Receive-side counterpart of the transmit trigger generator. On each rising edge of the trigger pulse it waits a programmable delay, then stores a gated window of ADC echo samples into an internal buffer. It also tracks the peak amplitude and its position within the gate and raises a flaw flag against a threshold. A host-side reader fetches the stored A-scan through a registered random-access port.

## Interface
Parameters:
- AW, 10, buffer address width; depth = 2^AW samples
- DW, 8, ADC sample width

Ports:
- clk  in  1  100 MHz system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  capture enable; low aborts and holds IDLE
- trig  in  1  transmit trigger, synchronous to clk; rising edge starts acquisition
- adc_data  in  DW  echo sample, valid every clk
- delay  in  16  samples skipped after trigger edge (10 ns units)
- length  in  AW+1  gate length in samples; values > 2^AW clamp to 2^AW
- threshold  in  DW  flaw threshold
- rd_en  in  1  read strobe
- rd_addr  in  AW  read address
- rd_data  out  DW  buffer word, one cycle after rd_en
- busy  out  1  high in DELAY or CAPTURE
- done  out  1  high from gate end until next accepted trigger, abort or reset
- peak  out  DW  maximum stored sample in last completed gate
- peak_idx  out  AW  buffer address of first occurrence of peak
- flaw  out  1  peak >= threshold, evaluated at gate end
- overrun  out  8  saturating count of trigger edges ignored while busy

## Operation
- Edge detect: trig_d registered; edge = trig & ~trig_d.
- FSM states: IDLE, DELAY, CAPTURE, DONE.
- IDLE/DONE + edge + en:
  - latch delay and clamped length;
  - clear peak, peak_idx, flaw and done;
  - go to DELAY, or to CAPTURE when delay == 0.
- Latched length == 0: go straight to DONE; peak 0, flaw = (threshold == 0).
- DELAY: count down latched delay; at 0 go to CAPTURE.
- CAPTURE:
  - write sample to address wr_ptr, starting at 0;
  - update peak/peak_idx when sample > peak (strict; ties keep earliest);
  - after the last write go to DONE and evaluate flaw.
- Edge while in DELAY/CAPTURE: ignored; overrun += 1, saturating at 255.
- en low in any state: next state IDLE, busy = 0, done = 0; buffer contents are retained.
- Reads are allowed in every state. Addresses not written in the last gate return stale data. Read and write on the same cycle return the old word.
- Input changes to delay, length or threshold after latching have no effect until the next accepted trigger.

## Timing
- E0 = first clk edge with trig = 1 after trig was 0.
- Address k holds adc_data sampled at edge E0 + 1 + delay + k, for k = 0..length-1.
- busy is high from after E0 until after edge E0 + delay + length.
- done, peak, peak_idx and flaw are valid after edge E0 + delay + length + 1.
- rd_data updates on the edge after rd_en; it holds when rd_en = 0.
- A trigger edge coinciding with the DONE-entry edge counts as an overrun.
- A trigger edge in DONE is accepted, which gives back-to-back gates with one dead cycle.
- Reset values: state IDLE, busy 0, done 0, peak 0, peak_idx 0, flaw 0, overrun 0, rd_data 0, trig_d 0.
- Reset mid-capture returns immediately to IDLE; buffer contents are undefined.

## Configuration
- ECHO_RECTIFY_EN defined:
  - samples pass through full-wave rectification about midscale before storage and peak detect;
  - r = adc ≥ 2^(DW-1) ? adc − 2^(DW-1) : 2^(DW-1) − 1 − adc;
  - stored value = {r, 1'b0}, i.e. range 0..254 for DW = 8;
  - this adds one pipeline register, so address k holds the rectified sample of edge E0 + 1 + delay + k, and all outputs shift one cycle later.
- Not defined: raw adc_data is stored and compared; no extra latency.

## Test plan
- delay = 3, length = 8, adc ramp 0,1,2,… per clk, trig pulse → after a full read, addresses 0..7 contain consecutive values, with address 0 = ramp value at E0 + 4; peak_idx = 7; done high at E0 + 12.
- length = 4, samples 10, 50, 50, 20, threshold = 50 → peak = 50, peak_idx = 1, flaw = 1. Repeat with threshold = 51 → flaw = 0.
- Second trig edge during DELAY, and a third during CAPTURE → overrun = 2; capture of the first gate unaffected. Run 300 ignored edges → overrun = 255.
- en dropped mid-CAPTURE → busy = 0, done = 0 next cycle. Re-enable plus trig → normal capture.
- length = 0 → done after E0 + 1 + delay; peak = 0. length = 2000 with AW = 10 → exactly 1024 samples written, then done.
- rst asserted mid-DELAY → all outputs at reset values immediately. With ECHO_RECTIFY_EN: samples 0, 127, 128, 255 → stored 254, 0, 0, 254.
